// File: rtl/hsv_core_foo_exec.sv
// -----------------------------------------------------------------------------
// hsv_core_foo_exec
//
// Execution unit for the custom "foo" major opcodes. It takes one decoded foo
// operation plus its operand values from decode/issue and returns one result
// toward commit/writeback. Only one operation is ever in flight.
//
// Operations (in_op):
//   0 CLMUL  : low 32 bits of the carry-less product rs1 * rs2 (iterative)
//   1 CLMULH : high 32 bits of the carry-less product rs1 * rs2 (iterative)
//   2 POPC   : number of set bits in rs1 (single cycle)
//   3 ROL    : rs1 rotated left by rs2[4:0] (single cycle)
//
// Parameters:
//   ITER_BITS : multiplier bits consumed per BUSY cycle (1, 2, 4 or 8)
//   TOKEN_W   : width of the opaque commit token carried through
//
// Ports:
//   clk_core   in   core clock
//   rst_core   in   synchronous active-high reset
//   flush      in   kills the in-flight op, highest priority after reset
//   in_valid   in   operation offered
//   in_ready   out  unit can accept (IDLE, not flushing, not in reset)
//   in_op      in   operation select
//   in_rs1     in   operand A
//   in_rs2     in   operand B / rotate amount
//   in_rd      in   destination register
//   in_token   in   commit token
//   out_valid  out  result available
//   out_ready  in   consumer accepts result
//   out_result out  result word
//   out_rd     out  registered copy of in_rd
//   out_token  out  registered copy of in_token
//
// Optional feature macro: HSV_CORE_FOO_EARLY_EXIT_EN
//   When defined, a carry-less multiply finishes as soon as the remaining
//   multiplier bits are all zero instead of always running 32/ITER_BITS
//   BUSY cycles. Results are identical either way.
// -----------------------------------------------------------------------------
module hsv_core_foo_exec #(
  parameter int ITER_BITS = 4,
  parameter int TOKEN_W   = 8
) (
  input  logic               clk_core,
  input  logic               rst_core,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         in_op,
  input  logic [31:0]        in_rs1,
  input  logic [31:0]        in_rs2,
  input  logic [4:0]         in_rd,
  input  logic [TOKEN_W-1:0] in_token,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_result,
  output logic [4:0]         out_rd,
  output logic [TOKEN_W-1:0] out_token
);

  localparam int N     = 32 / ITER_BITS;
  localparam int CNT_W = $clog2(N) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [63:0]        acc_q, acc_d;
  logic [63:0]        mcand_q, mcand_d;
  logic [31:0]        mplier_q, mplier_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        result_q, result_d;
  logic [4:0]         rd_q, rd_d;
  logic [TOKEN_W-1:0] token_q, token_d;

  logic               accept;
  logic               isMul;
  logic               lastChunk;
  logic [63:0]        partial;
  logic [63:0]        accNext;
  logic [31:0]        mplierNext;
  logic [4:0]         rotAmt;
  logic [31:0]        rotResult;
  logic [31:0]        popResult;
  logic [31:0]        quickResult;

  // Handshake qualification. in_ready is a pure function of state, flush and
  // reset so that upstream never sees a combinational path from in_valid.
  always_comb begin
    in_ready = (state_q == IDLE) && !flush && !rst_core;
    accept   = in_valid && in_ready;
    isMul    = !in_op[1];
  end

  // Single-cycle operations are computed straight from the operands at
  // accept time. The rotate uses the two-shift form; a shift by 32 of a
  // 32-bit value yields zero, which makes a zero rotate amount fall out
  // naturally.
  always_comb begin
    rotAmt      = in_rs2[4:0];
    rotResult   = (in_rs1 << rotAmt) | (in_rs1 >> (6'd32 - {1'b0, rotAmt}));
    popResult   = 32'($countones(in_rs1));
    quickResult = in_op[0] ? rotResult : popResult;
  end

  // One multiply step: fold in the shifted multiplicand for every set bit in
  // the low ITER_BITS of the remaining multiplier.
  always_comb begin
    partial = '0;
    for (int i = 0; i < ITER_BITS; i++) begin
      if (mplier_q[i]) begin
        partial = partial ^ (mcand_q << i);
      end
    end
    accNext    = acc_q ^ partial;
    mplierNext = mplier_q >> ITER_BITS;
  end

  // Decide whether the current BUSY cycle is the final chunk. With early exit
  // enabled, a multiplier that has run out of set bits ends the iteration,
  // since further chunks would only XOR in zeros.
  always_comb begin
`ifdef HSV_CORE_FOO_EARLY_EXIT_EN
    lastChunk = (cnt_q == CNT_W'(N - 1)) || (mplierNext == 32'd0);
`else
    lastChunk = (cnt_q == CNT_W'(N - 1));
`endif
  end

  // State register: synchronous reset returns everything to zero and IDLE.
  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      state_q  <= IDLE;
      op_q     <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      rd_q     <= '0;
      token_q  <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      rd_q     <= rd_d;
      token_q  <= token_d;
    end
  end

  // Next-state logic. Flush overrides every transition and always lands in
  // IDLE, which also discards a finished result even if it is being accepted
  // in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = isMul ? BUSY : DONE;
        end
      end
      BUSY: begin
        if (lastChunk) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
    end
  end

  // Datapath next-state. On accept all operation context is captured; the
  // single-cycle ops write their result immediately. During BUSY the
  // multiplier is consumed LSB first and the result word is captured on the
  // final chunk so the DONE outputs stay frozen under backpressure.
  always_comb begin
    op_d     = op_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    rd_d     = rd_q;
    token_d  = token_q;
    if (accept) begin
      op_d     = in_op;
      rd_d     = in_rd;
      token_d  = in_token;
      acc_d    = '0;
      mcand_d  = {32'd0, in_rs1};
      mplier_d = in_rs2;
      cnt_d    = '0;
      if (!isMul) begin
        result_d = quickResult;
      end
    end else if ((state_q == BUSY) && !flush) begin
      acc_d    = accNext;
      mcand_d  = mcand_q << ITER_BITS;
      mplier_d = mplierNext;
      cnt_d    = cnt_q + CNT_W'(1);
      if (lastChunk) begin
        result_d = op_q[0] ? accNext[63:32] : accNext[31:0];
      end
    end
  end

  // Output logic: everything on the result side is registered state.
  always_comb begin
    out_valid  = (state_q == DONE);
    out_result = result_q;
    out_rd     = rd_q;
    out_token  = token_q;
  end

endmodule

// File: tb/tb_hsv_core_foo_exec.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_hsv_core_foo_exec
//
// Directed testbench for hsv_core_foo_exec with default parameters
// (ITER_BITS=4, TOKEN_W=8). A table of operations with hand-computed results
// and BUSY-cycle counts is run through the unit, followed by hand-written
// sequences for reset, backpressure, flush and reset in mid-operation.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_hsv_core_foo_exec;

  localparam int N = 8;
`ifdef HSV_CORE_FOO_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  localparam logic [1:0] OP_CLMUL  = 2'd0;
  localparam logic [1:0] OP_CLMULH = 2'd1;
  localparam logic [1:0] OP_POPC   = 2'd2;
  localparam logic [1:0] OP_ROL    = 2'd3;

  logic        clk_core = 1'b0;
  logic        rst_core;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_rs1;
  logic [31:0] in_rs2;
  logic [4:0]  in_rd;
  logic [7:0]  in_token;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic [7:0]  out_token;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] expResult;
    int          earlyBusy;
  } vec_t;

  vec_t vecs[16];

  hsv_core_foo_exec #(
    .ITER_BITS(4),
    .TOKEN_W  (8)
  ) dut (
    .clk_core  (clk_core),
    .rst_core  (rst_core),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_rd     (in_rd),
    .in_token  (in_token),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result),
    .out_rd    (out_rd),
    .out_token (out_token)
  );

  // Free-running core clock, 10 ns period.
  always #5 clk_core = ~clk_core;

  // Watchdog so a stuck design still ends the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Cycles from the accept cycle to the first out_valid cycle.
  function automatic int expLatency(input logic [1:0] op, input int earlyBusy);
    if (op[1]) return 1;
    return EARLY ? earlyBusy + 1 : N + 1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] rs1,
                               input logic [31:0] rs2, input logic [4:0] rd,
                               input logic [7:0] tok);
    in_valid = 1'b1;
    in_op    = op;
    in_rs1   = rs1;
    in_rs2   = rs2;
    in_rd    = rd;
    in_token = tok;
  endtask

  // Called at the negedge of the cycle after accept; waits (bounded) for
  // out_valid and checks latency and payload. out_ready is expected high,
  // so the result is consumed on the following edge.
  task automatic waitResult(input string tag, input int expLat,
                            input logic [31:0] expRes, input logic [4:0] rd,
                            input logic [7:0] tok);
    int lat;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk_core);
      lat++;
    end
    checkOutput($sformatf("%s_latency", tag), 32'(lat), 32'(expLat));
    if (out_valid) begin
      checkOutput($sformatf("%s_result", tag), out_result, expRes);
      checkOutput($sformatf("%s_rd", tag), 32'(out_rd), 32'(rd));
      checkOutput($sformatf("%s_token", tag), 32'(out_token), 32'(tok));
    end
    @(negedge clk_core);
  endtask

  // Full single operation from an idle unit: offer, accept, collect.
  task automatic runOp(input string tag, input logic [1:0] op,
                       input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [4:0] rd, input logic [7:0] tok,
                       input logic [31:0] expRes, input int expLat);
    applyStimulus(op, rs1, rs2, rd, tok);
    #1;
    checkOutput($sformatf("%s_in_ready", tag), 32'(in_ready), 32'd1);
    @(negedge clk_core);
    in_valid = 1'b0;
    waitResult(tag, expLat, expRes, rd, tok);
  endtask

  initial begin
    int sawValid;

    vecs[0]  = '{OP_CLMUL,  32'h00000003, 32'h00000003, 32'h00000005, 1};
    vecs[1]  = '{OP_CLMULH, 32'h80000000, 32'h80000000, 32'h40000000, 8};
    vecs[2]  = '{OP_POPC,   32'hF0F00001, 32'h00000000, 32'h00000009, 0};
    vecs[3]  = '{OP_ROL,    32'h80000001, 32'hFFFFFFE4, 32'h00000018, 0};
    vecs[4]  = '{OP_CLMUL,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h55555555, 8};
    vecs[5]  = '{OP_CLMULH, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h55555555, 8};
    vecs[6]  = '{OP_CLMUL,  32'h12345678, 32'h00000000, 32'h00000000, 1};
    vecs[7]  = '{OP_CLMUL,  32'h00000001, 32'hDEADBEEF, 32'hDEADBEEF, 8};
    vecs[8]  = '{OP_CLMULH, 32'h00000001, 32'hDEADBEEF, 32'h00000000, 8};
    vecs[9]  = '{OP_CLMUL,  32'h00000003, 32'h00000100, 32'h00000300, 3};
    vecs[10] = '{OP_CLMULH, 32'hF0000000, 32'h00000010, 32'h0000000F, 2};
    vecs[11] = '{OP_ROL,    32'h12345678, 32'h00000000, 32'h12345678, 0};
    vecs[12] = '{OP_ROL,    32'h00000003, 32'h0000001F, 32'h80000001, 0};
    vecs[13] = '{OP_POPC,   32'h00000000, 32'h00000000, 32'h00000000, 0};
    vecs[14] = '{OP_POPC,   32'hFFFFFFFF, 32'h00000000, 32'h00000020, 0};
    vecs[15] = '{OP_CLMUL,  32'h00000005, 32'h00000007, 32'h0000001B, 1};

    // Reset held for two cycles with an operation offered.
    rst_core  = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b1;
    applyStimulus(OP_CLMUL, 32'h3, 32'h3, 5'd9, 8'h11);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk_core);
      checkOutput($sformatf("reset_in_ready_%0d", k), 32'(in_ready), 32'd0);
      checkOutput($sformatf("reset_out_valid_%0d", k), 32'(out_valid), 32'd0);
    end
    rst_core = 1'b0;
    in_valid = 1'b0;
    #1;
    checkOutput("post_reset_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk_core);
    checkOutput("post_reset_out_valid", 32'(out_valid), 32'd0);

    // Table-driven operations.
    for (int i = 0; i < 16; i++) begin
      runOp($sformatf("vec%0d", i), vecs[i].op, vecs[i].rs1, vecs[i].rs2,
            5'(i * 3 + 1), 8'(8'h40 + i * 7), vecs[i].expResult,
            expLatency(vecs[i].op, vecs[i].earlyBusy));
    end

    // Backpressure: POPC result held for three stalled cycles while the next
    // op is already offered, then consumed; the ROL is accepted one cycle
    // after the output handshake.
    out_ready = 1'b0;
    applyStimulus(OP_POPC, 32'hF0F00001, 32'h0, 5'd3, 8'h5A);
    @(negedge clk_core);
    applyStimulus(OP_ROL, 32'h80000001, 32'hFFFFFFE4, 5'd4, 8'h6B);
    for (int k = 0; k < 3; k++) begin
      #1;
      checkOutput($sformatf("bp_stall_valid_%0d", k), 32'(out_valid), 32'd1);
      checkOutput($sformatf("bp_stall_result_%0d", k), out_result, 32'd9);
      checkOutput($sformatf("bp_stall_rd_%0d", k), 32'(out_rd), 32'd3);
      checkOutput($sformatf("bp_stall_token_%0d", k), 32'(out_token), 32'h5A);
      checkOutput($sformatf("bp_stall_in_ready_%0d", k), 32'(in_ready), 32'd0);
      @(negedge clk_core);
    end
    out_ready = 1'b1;
    #1;
    checkOutput("bp_release_valid", 32'(out_valid), 32'd1);
    checkOutput("bp_release_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk_core);
    #1;
    checkOutput("bp_idle_valid", 32'(out_valid), 32'd0);
    checkOutput("bp_idle_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk_core);
    in_valid = 1'b0;
    waitResult("bp_rol", 1, 32'h00000018, 5'd4, 8'h6B);

    // Flush during BUSY at C+3 with in_valid held high; a new CLMUL is then
    // accepted at C+4 and must complete with its normal latency.
    applyStimulus(OP_CLMUL, 32'h3, 32'hFFFFFFFF, 5'd10, 8'h77);
    @(negedge clk_core);
    checkOutput("flush_busy_c1_valid", 32'(out_valid), 32'd0);
    applyStimulus(OP_CLMUL, 32'h3, 32'h3, 5'd11, 8'h88);
    @(negedge clk_core);
    checkOutput("flush_busy_c2_valid", 32'(out_valid), 32'd0);
    @(negedge clk_core);
    flush = 1'b1;
    #1;
    checkOutput("flush_busy_c3_in_ready", 32'(in_ready), 32'd0);
    checkOutput("flush_busy_c3_valid", 32'(out_valid), 32'd0);
    @(negedge clk_core);
    flush = 1'b0;
    #1;
    checkOutput("flush_busy_c4_valid", 32'(out_valid), 32'd0);
    checkOutput("flush_busy_c4_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk_core);
    in_valid = 1'b0;
    waitResult("flush_busy_next", expLatency(OP_CLMUL, 1), 32'h5, 5'd11, 8'h88);

    // Flush in DONE with out_ready high: the result is dropped.
    applyStimulus(OP_POPC, 32'h000000FF, 32'h0, 5'd12, 8'h99);
    @(negedge clk_core);
    in_valid = 1'b0;
    checkOutput("flush_done_valid", 32'(out_valid), 32'd1);
    flush = 1'b1;
    #1;
    checkOutput("flush_done_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk_core);
    flush = 1'b0;
    #1;
    checkOutput("flush_done_next_valid", 32'(out_valid), 32'd0);
    checkOutput("flush_done_next_in_ready", 32'(in_ready), 32'd1);
    sawValid = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_core);
      if (out_valid) sawValid++;
    end
    checkOutput("flush_done_no_valid", 32'(sawValid), 32'd0);
    runOp("after_flush_done", OP_POPC, 32'h0000000F, 32'h0, 5'd13, 8'h21, 32'd4, 1);

    // Reset in the middle of a multiply: no result may appear afterwards.
    applyStimulus(OP_CLMUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd14, 8'h31);
    @(negedge clk_core);
    in_valid = 1'b0;
    @(negedge clk_core);
    rst_core = 1'b1;
    #1;
    checkOutput("midreset_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk_core);
    rst_core = 1'b0;
    sawValid = 0;
    for (int k = 0; k < N + 4; k++) begin
      @(negedge clk_core);
      if (out_valid) sawValid++;
    end
    checkOutput("midreset_no_valid", 32'(sawValid), 32'd0);
    runOp("after_midreset", OP_CLMULH, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd15, 8'h42,
          32'h55555555, expLatency(OP_CLMULH, 8));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hsv_core_foo_exec.md
Name: hsv_core_foo_exec

Overview:
- Execution unit for the custom "foo" major opcodes. Sits directly downstream of foo decode/issue: consumes one decoded foo operation plus operand values and returns one result toward commit/writeback.
- Implements four ops: iterative carry-less multiply (low and high word), single-cycle popcount and rotate-left.
- Valid/ready handshakes on both sides. One operation in flight at a time. Flush support.

Parameters:
- ITER_BITS, 4, multiplier bits consumed per BUSY cycle; legal values 1, 2, 4, 8.
- TOKEN_W, 8, width of the opaque commit token carried through.

Ports:
- clk_core  in  1  core clock
- rst_core  in  1  synchronous active-high reset
- flush  in  1  kill the in-flight op; has priority over everything except reset
- in_valid  in  1  operation offered
- in_ready  out  1  unit can accept
- in_op  in  2  0=CLMUL, 1=CLMULH, 2=POPC, 3=ROL
- in_rs1  in  32  operand A
- in_rs2  in  32  operand B / shift amount
- in_rd  in  5  destination register
- in_token  in  TOKEN_W  commit token
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_result  out  32  result word
- out_rd  out  5  destination, registered copy of in_rd
- out_token  out  TOKEN_W  registered copy of in_token

Behaviour:
- Clocking and reset: one clock, clk_core. rst_core is synchronous and active-high.
- Reset values:
  - state=IDLE, out_valid=0.
  - out_result, out_rd, out_token = 0.
  - Internal accumulator, counter and multiplier registers = 0.
  - in_ready=0 while rst_core is high.
- States: IDLE, BUSY, DONE.
- Ready: in_ready = (state==IDLE) && !flush && !rst_core. Purely combinational from state; never depends on in_valid.
- Accept: handshake in cycle C when in_valid && in_ready. rd, token and op are latched.
- POPC:
  - out_result = number of set bits of rs1, zero-extended.
  - State goes IDLE->DONE; out_valid high in cycle C+1.
- ROL:
  - out_result = rs1 rotated left by rs2[4:0]; upper bits of rs2 are ignored.
  - Latency same as POPC.
- CLMUL/CLMULH:
  - Registers: 64-bit acc=0, 64-bit mcand={32'b0,rs1}, 32-bit mplier=rs2, chunk counter=0. State -> BUSY.
  - Each BUSY cycle processes mplier[ITER_BITS-1:0] from LSB: for every set bit i, acc ^= mcand<<i. Then mcand <<= ITER_BITS, mplier >>= ITER_BITS, counter++.
  - N = 32/ITER_BITS BUSY cycles: cycles C+1..C+N, DONE in C+N+1.
  - CLMUL returns acc[31:0]; CLMULH returns acc[63:32].
  - Counter width = clog2(N)+1. Transition to DONE when counter reaches N-1 in a BUSY cycle; no wrap.
- DONE:
  - out_valid=1. Outputs are stable while out_valid && !out_ready.
  - On out_valid && out_ready -> IDLE. No new accept in that same cycle; the earliest next accept is the following cycle.
- Flush:
  - In any state, the next state is IDLE and out_valid=0 next cycle.
  - A result in DONE is discarded even if out_ready is high in the flush cycle; the consumer must ignore it.
  - in_ready is low in the flush cycle.
- Reset mid-operation: same as flush, plus all registers cleared.
- X-safety: out_result, out_rd and out_token are don't-care when out_valid=0; the bench must not check them.

Optional Feature:
- Macro: HSV_CORE_FOO_EARLY_EXIT_EN.
- Defined: in a BUSY cycle, if the post-shift mplier is zero, go to DONE at the end of that cycle regardless of counter. CLMUL/CLMULH latency becomes ceil((msb_index(rs2)+1)/ITER_BITS) BUSY cycles, minimum 1 (rs2=0 takes 1 BUSY cycle). Results are identical to the non-early-exit case.
- Undefined: CLMUL/CLMULH always take exactly N BUSY cycles.

Test Plan:
- Reset: hold rst_core 2 cycles with in_valid=1 -> in_ready=0, out_valid=0; after release, in_ready=1 in the first cycle.
- CLMUL, ITER_BITS=4, rs1=3, rs2=3, accept in cycle C:
  - out_result=0x00000005, out_valid first high in C+9.
  - With HSV_CORE_FOO_EARLY_EXIT_EN: first high in C+2.
- CLMULH, rs1=0x80000000, rs2=0x80000000 -> out_result=0x40000000. out_rd and out_token equal the accepted values.
- POPC rs1=0xF0F00001 -> 9 in C+1. ROL rs1=0x80000001, rs2=0xFFFFFFE4 -> 0x00000018 in C+1. Hold out_ready=0 for 3 cycles: outputs stable, in_ready=0. Release: returns to IDLE; a back-to-back second op is accepted the cycle after the output handshake.
- Flush during BUSY at C+3, in_valid held high:
  - out_valid never asserts for that op; in_ready=1 at C+4.
  - A new CLMUL accepted at C+4 returns the correct result with full latency.
- Flush in DONE with out_ready=1 in the same cycle: result dropped, no further out_valid, state IDLE next cycle.
